// File: rtl/controle_deplacement_if.sv
// Player-side and pile-side signals of the move controller.
// The move controller is the slave; the board or the bench drives it as the master.
interface controle_deplacement_if #(
    parameter int LARGEUR = 3
);
    logic [2:0]         btn_pile;
    logic               btn_annule;
    logic [LARGEUR-1:0] hauteur0;
    logic [LARGEUR-1:0] hauteur1;
    logic [LARGEUR-1:0] hauteur2;
    logic [2:0]         plus;
    logic [2:0]         moins;
    logic [2:0]         src_sel;
    logic               erreur;
    logic [7:0]         nb_coups;

    modport master (
        output btn_pile, btn_annule, hauteur0, hauteur1, hauteur2,
        input  plus, moins, src_sel, erreur, nb_coups
    );

    modport slave (
        input  btn_pile, btn_annule, hauteur0, hauteur1, hauteur2,
        output plus, moins, src_sel, erreur, nb_coups
    );
endinterface

// File: rtl/controle_deplacement.sv
// Move controller: turns pushbuttons into legal single-brick moves between three piles,
// issuing one moins/plus pulse pair per move, flagging illegal moves and counting moves.
module controle_deplacement #(
    parameter int LARGEUR     = 3,
    parameter int HAUTEUR_MAX = 7,
    parameter int ERR_CYCLES  = 4
) (
    input logic             clk,
    input logic             reset,
    controle_deplacement_if.slave bus
);

    localparam int CW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

    typedef enum logic [1:0] {ATT_SRC, ATT_DST, EXECUTE, ERREUR} etat_t;

    logic [3:0] brut;
    logic [3:0] evt;
    logic [1:0] amorce_reg;
    logic       amorce_ok;

    assign brut      = {bus.btn_annule, bus.btn_pile};
    assign amorce_ok = (amorce_reg == 2'd3);

    // Events stay masked until the synchronizers hold post-reset samples, so a
    // button held through reset release never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (!reset)
            amorce_reg <= 2'd0;
        else if (!amorce_ok)
            amorce_reg <= amorce_reg + 2'd1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;
            logic retard_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    retard_reg <= 1'b0;
                end else begin
                    sync1_reg  <= brut[gi];
                    sync2_reg  <= sync1_reg;
                    retard_reg <= sync2_reg;
                end
            end

            assign evt[gi] = sync2_reg & ~retard_reg & amorce_ok;
        end
    endgenerate

    logic [2:0]         ev_pile;
    logic               ev_annule;
    logic               un_seul;
    logic [1:0]         idx;
    logic [LARGEUR-1:0] h_sel;

    assign ev_pile   = evt[2:0];
    assign ev_annule = evt[3];
    assign un_seul   = (ev_pile == 3'b001) || (ev_pile == 3'b010) || (ev_pile == 3'b100);

    always_comb begin
        idx   = 2'd0;
        h_sel = bus.hauteur0;
        case (ev_pile)
            3'b010: begin
                idx   = 2'd1;
                h_sel = bus.hauteur1;
            end
            3'b100: begin
                idx   = 2'd2;
                h_sel = bus.hauteur2;
            end
            default: begin
                idx   = 2'd0;
                h_sel = bus.hauteur0;
            end
        endcase
    end

    function automatic logic [2:0] un_parmi(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    etat_t         state_reg, state_next;
    logic [1:0]    src_reg, src_next;
    logic [1:0]    dst_reg, dst_next;
    logic [2:0]    src_sel_reg, src_sel_next;
    logic [2:0]    plus_reg, plus_next;
    logic [2:0]    moins_reg, moins_next;
    logic          erreur_reg, erreur_next;
    logic [CW-1:0] err_cnt_reg, err_cnt_next;
    logic [7:0]    nb_coups_reg, nb_coups_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ATT_SRC;
            src_reg      <= 2'd0;
            dst_reg      <= 2'd0;
            src_sel_reg  <= 3'b000;
            plus_reg     <= 3'b000;
            moins_reg    <= 3'b000;
            erreur_reg   <= 1'b0;
            err_cnt_reg  <= '0;
            nb_coups_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            src_reg      <= src_next;
            dst_reg      <= dst_next;
            src_sel_reg  <= src_sel_next;
            plus_reg     <= plus_next;
            moins_reg    <= moins_next;
            erreur_reg   <= erreur_next;
            err_cnt_reg  <= err_cnt_next;
            nb_coups_reg <= nb_coups_next;
        end
    end

    // plus/moins are loaded on the way into EXECUTE so they are high exactly
    // during the EXECUTE cycle; likewise erreur is high exactly while in ERREUR.
    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        dst_next      = dst_reg;
        src_sel_next  = src_sel_reg;
        plus_next     = 3'b000;
        moins_next    = 3'b000;
        erreur_next   = 1'b0;
        err_cnt_next  = err_cnt_reg;
        nb_coups_next = nb_coups_reg;

        case (state_reg)
            ATT_SRC: begin
                if (un_seul) begin
                    if (h_sel == '0) begin
                        state_next   = ERREUR;
                        erreur_next  = 1'b1;
                        err_cnt_next = '0;
                    end else begin
                        src_next     = idx;
                        src_sel_next = un_parmi(idx);
                        state_next   = ATT_DST;
                    end
                end
            end

            ATT_DST: begin
                if (ev_annule) begin
                    src_sel_next = 3'b000;
                    state_next   = ATT_SRC;
                end else if (un_seul) begin
                    if (idx == src_reg) begin
                        src_sel_next = 3'b000;
                        state_next   = ATT_SRC;
                    end else if (h_sel >= LARGEUR'(HAUTEUR_MAX)) begin
                        src_sel_next = 3'b000;
                        state_next   = ERREUR;
                        erreur_next  = 1'b1;
                        err_cnt_next = '0;
                    end else begin
                        dst_next   = idx;
                        moins_next = un_parmi(src_reg);
                        plus_next  = un_parmi(idx);
                        state_next = EXECUTE;
                    end
                end
            end

            EXECUTE: begin
                src_sel_next  = 3'b000;
                nb_coups_next = (nb_coups_reg == 8'hFF) ? nb_coups_reg : nb_coups_reg + 8'd1;
                state_next    = ATT_SRC;
            end

            ERREUR: begin
                if (err_cnt_reg == CW'(ERR_CYCLES - 1)) begin
                    state_next = ATT_SRC;
                end else begin
                    erreur_next  = 1'b1;
                    err_cnt_next = err_cnt_reg + 1'b1;
                end
            end

            default: state_next = ATT_SRC;
        endcase
    end

    assign bus.plus     = plus_reg;
    assign bus.moins    = moins_reg;
    assign bus.src_sel  = src_sel_reg;
    assign bus.erreur   = erreur_reg;
    assign bus.nb_coups = nb_coups_reg;

endmodule

// File: tb/tb_controle_deplacement.sv
// Directed bench for controle_deplacement: legal moves, illegal moves, cancel,
// held buttons, move-count saturation and reset in the middle of a move.
module tb_controle_deplacement;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    controle_deplacement_if #(.LARGEUR(3)) bus ();

    controle_deplacement #(
        .LARGEUR    (3),
        .HAUTEUR_MAX(7),
        .ERR_CYCLES (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int nb_verifs  = 0;
    int nb_erreurs = 0;

    // Cycle-level monitors, sampled well after the rising edge.
    int n_impulsions = 0;
    int n_err_hi     = 0;
    int n_conflits   = 0;

    always begin
        @(posedge clk);
        #2;
        if (bus.plus != 3'b000 || bus.moins != 3'b000) n_impulsions++;
        if (bus.erreur) n_err_hi++;
        if ((bus.plus & bus.moins) != 3'b000) n_conflits++;
    end

    task automatic verifier(input string tag, input int obs, input int att);
        nb_verifs++;
        if (obs !== att) begin
            nb_erreurs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, att);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Called on a falling edge; returns on the falling edge right after the
    // rising edge where the press takes effect (third edge after the raise).
    task automatic appuyer(input logic [2:0] p, input logic a);
        bus.btn_pile   = p;
        bus.btn_annule = a;
        @(negedge clk);
        bus.btn_pile   = 3'b000;
        bus.btn_annule = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic hauteurs(input logic [2:0] h0, input logic [2:0] h1, input logic [2:0] h2);
        bus.hauteur0 = h0;
        bus.hauteur1 = h1;
        bus.hauteur2 = h2;
    endtask

    task automatic sorties_nulles(input string tag);
        verifier({tag, " plus"},     int'(bus.plus),     0);
        verifier({tag, " moins"},    int'(bus.moins),    0);
        verifier({tag, " src_sel"},  int'(bus.src_sel),  0);
        verifier({tag, " erreur"},   int'(bus.erreur),   0);
        verifier({tag, " nb_coups"}, int'(bus.nb_coups), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_imp;
        int base_err;
        int attendu;

        reset          = 1'b0;
        bus.btn_pile   = 3'b000;
        bus.btn_annule = 1'b0;
        hauteurs(3'd3, 3'd0, 3'd0);
        repeat (3) @(negedge clk);
        sorties_nulles("reset");
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Legal move 0 -> 1
        base_imp = n_impulsions;
        appuyer(3'b001, 1'b0);
        verifier("move src_sel", int'(bus.src_sel), 1);
        appuyer(3'b010, 1'b0);
        verifier("move moins", int'(bus.moins), 1);
        verifier("move plus",  int'(bus.plus),  2);
        @(negedge clk);
        verifier("move pulse gone", int'(bus.plus | bus.moins), 0);
        verifier("move nb_coups",   int'(bus.nb_coups), 1);
        verifier("move src_sel clr", int'(bus.src_sel), 0);
        verifier("move one pulse",  n_impulsions - base_imp, 1);

        // Empty source, with a press during the error window
        base_imp = n_impulsions;
        base_err = n_err_hi;
        appuyer(3'b100, 1'b0);
        for (int i = 0; i < 4; i++) begin
            verifier($sformatf("empty erreur c%0d", i), int'(bus.erreur), 1);
            bus.btn_pile = (i == 0) ? 3'b001 : 3'b000;
            @(negedge clk);
        end
        bus.btn_pile = 3'b000;
        verifier("empty erreur end", int'(bus.erreur), 0);
        repeat (3) @(negedge clk);
        verifier("empty press ignored", int'(bus.src_sel), 0);
        verifier("empty err cycles", n_err_hi - base_err, 4);
        verifier("empty no pulse", n_impulsions - base_imp, 0);

        // Full destination, then deselect
        hauteurs(3'd2, 3'd7, 3'd0);
        base_imp = n_impulsions;
        base_err = n_err_hi;
        appuyer(3'b001, 1'b0);
        verifier("full src_sel", int'(bus.src_sel), 1);
        appuyer(3'b010, 1'b0);
        verifier("full erreur", int'(bus.erreur), 1);
        verifier("full src_sel clr", int'(bus.src_sel), 0);
        repeat (4) @(negedge clk);
        verifier("full erreur end", int'(bus.erreur), 0);
        verifier("full err cycles", n_err_hi - base_err, 4);
        verifier("full nb_coups", int'(bus.nb_coups), 1);
        appuyer(3'b001, 1'b0);
        verifier("desel first", int'(bus.src_sel), 1);
        appuyer(3'b001, 1'b0);
        verifier("desel second", int'(bus.src_sel), 0);
        verifier("desel erreur", int'(bus.erreur), 0);
        repeat (2) @(negedge clk);
        verifier("desel no pulse", n_impulsions - base_imp, 0);

        // Simultaneous presses and cancel
        hauteurs(3'd3, 3'd0, 3'd3);
        base_imp = n_impulsions;
        appuyer(3'b101, 1'b0);
        verifier("simul ignored", int'(bus.src_sel), 0);
        verifier("simul no erreur", int'(bus.erreur), 0);
        appuyer(3'b001, 1'b0);
        verifier("cancel src_sel", int'(bus.src_sel), 1);
        appuyer(3'b010, 1'b1);
        verifier("cancel cleared", int'(bus.src_sel), 0);
        repeat (2) @(negedge clk);
        verifier("cancel no pulse", n_impulsions - base_imp, 0);
        verifier("cancel nb_coups", int'(bus.nb_coups), 1);

        // Held button: one event only (a second would deselect)
        bus.btn_pile = 3'b001;
        repeat (20) @(negedge clk);
        bus.btn_pile = 3'b000;
        repeat (3) @(negedge clk);
        verifier("held one event", int'(bus.src_sel), 1);
        appuyer(3'b000, 1'b1);
        verifier("held cancel", int'(bus.src_sel), 0);

        // Saturation of the move count
        hauteurs(3'd3, 3'd3, 3'd0);
        base_imp = n_impulsions;
        attendu  = 1;
        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) begin
                appuyer(3'b001, 1'b0);
                appuyer(3'b010, 1'b0);
            end else begin
                appuyer(3'b010, 1'b0);
                appuyer(3'b001, 1'b0);
            end
            @(negedge clk);
            attendu = (attendu == 255) ? 255 : attendu + 1;
            if (i == 252 || i == 253)
                verifier($sformatf("sat nb_coups move %0d", i), int'(bus.nb_coups), attendu);
        end
        verifier("sat nb_coups final", int'(bus.nb_coups), 255);
        verifier("sat pulses", n_impulsions - base_imp, 256);
        verifier("no plus+moins overlap", n_conflits, 0);

        // Reset during ERREUR
        appuyer(3'b100, 1'b0);
        verifier("rst-err in erreur", int'(bus.erreur), 1);
        reset = 1'b0;
        @(negedge clk);
        sorties_nulles("rst-err");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        appuyer(3'b001, 1'b0);
        verifier("rst-err reselect", int'(bus.src_sel), 1);

        // Reset during EXECUTE
        appuyer(3'b010, 1'b0);
        verifier("rst-exe moins", int'(bus.moins), 1);
        reset = 1'b0;
        @(negedge clk);
        sorties_nulles("rst-exe");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        appuyer(3'b001, 1'b0);
        verifier("rst-exe reselect", int'(bus.src_sel), 1);

        // Button held through reset release yields no event
        reset        = 1'b0;
        bus.btn_pile = 3'b010;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        verifier("held-rst src_sel", int'(bus.src_sel), 0);
        verifier("held-rst nb_coups", int'(bus.nb_coups), 0);
        bus.btn_pile = 3'b000;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nb_erreurs, nb_verifs);
        $finish;
    end

endmodule
